// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with run/pause/expire control.
// A prescaler divides clk by TICK_DIV; each prescaler wrap decrements q
// while running. Reaching zero by counting pulses done and enters EXPIRED.
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN -- on expiry the count
// is reloaded from the last loaded value and counting continues.
module countdown_timer #(
  parameter int WIDTH    = 16,
  parameter int TICK_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             done,
  output logic             expired
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  // Prescaler value on which the tick occurs.
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] q_next;
  logic [23:0]      presc, presc_next;
  logic             running_next, done_next, expired_next;

  // Value restored on expiry, and whether restoring is allowed at all.
  logic [WIDTH-1:0] reload_value;
  logic             reload_ok;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload;

  // Reload register: remembers the last loaded preset.
  always_ff @(posedge clk) begin
    if (reset) begin
      reload <= '0;
    end else if (load) begin
      reload <= load_value;
    end
  end

  assign reload_value = reload;
  assign reload_ok    = (reload != '0);
`else
  assign reload_value = '0;
  assign reload_ok    = 1'b0;
`endif

  // Next-state, count and prescaler logic; load beats start beats pause.
  always_comb begin
    state_next = state;
    q_next     = q;
    presc_next = presc;
    done_next  = 1'b0;

    if (load) begin
      q_next     = load_value;
      presc_next = '0;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (start && (q != '0)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (presc == TICK_LAST) begin
            presc_next = '0;
            if (q <= WIDTH'(1)) begin
              done_next = 1'b1;
              if (reload_ok) begin
                q_next = reload_value;
              end else begin
                q_next     = '0;
                state_next = EXPIRED;
              end
            end else begin
              q_next = q - WIDTH'(1);
            end
          end else begin
            presc_next = presc + 24'd1;
          end
          // A pause on the tick still lets the decrement land first.
          if (pause && !start && (state_next == RUN)) begin
            state_next = PAUSED;
          end
        end
        EXPIRED: begin
          q_next     = '0;
          presc_next = '0;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    running_next = (state_next == RUN);
    expired_next = (state_next == EXPIRED);
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      q       <= '0;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_next;
      q       <= q_next;
      presc   <= presc_next;
      running <= running_next;
      done    <= done_next;
      expired <= expired_next;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer (TICK_DIV=4). The model tracks the loaded value
// and the number of cycles spent running; q follows by integer division.
module tb_countdown_timer;

  localparam int W = 16;
  localparam int T = 4;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, load, start, pause;
  logic [W-1:0] load_value;
  logic [W-1:0] q;
  logic         running, done, expired;

  int checks   = 0;
  int failures = 0;

  // Model state: preset, cycles run since load, and status flags.
  int m_base = 0;
  int m_rc   = 0;
  bit m_run  = 1'b0;
  bit m_exp  = 1'b0;
  bit m_done = 1'b0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(W), .TICK_DIV(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .q          (q),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  function automatic int m_q();
    int k;
    k = m_rc / T;
    if (m_exp) return 0;
    if (AR && m_base != 0) return m_base - (k % m_base);
    return m_base - k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  qb, k;
    bit  was_run;
    if (reset) begin
      m_base = 0; m_rc = 0; m_run = 0; m_exp = 0; m_done = 0;
    end else if (load) begin
      m_base = int'(load_value); m_rc = 0; m_run = 0; m_exp = 0; m_done = 0;
    end else begin
      qb      = m_q();
      was_run = m_run;
      m_done  = 0;
      if (m_run) begin
        m_rc++;
        if (m_rc % T == 0) begin
          k = m_rc / T;
          if (AR && m_base != 0) begin
            if (k % m_base == 0) m_done = 1;
          end else if (k >= m_base) begin
            m_done = 1; m_exp = 1; m_run = 0;
          end
        end
      end
      if (start && !was_run && !m_exp && qb != 0) m_run = 1;
      else if (pause && !start && was_run) m_run = 0;
    end
  endtask

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("cyc_q", 32'(q), 32'(m_q()));
      check("cyc_running", 32'(running), 32'(m_run));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_expired", 32'(expired), 32'(m_exp));
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [W-1:0] v);
    load_value = v; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0; load_value = '0;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(10);
    check("idle_q", 32'(q), 32'd0);
    check("idle_running", 32'(running), 32'd0);

    // Basic countdown from 3: decrements at 4, 8, 12 cycles after start.
    pulse_load(16'd3);
    pulse_start();
    wait_cyc(3);
    check("cd3_q_before_tick", 32'(q), 32'd3);
    check("cd3_running", 32'(running), 32'd1);
    wait_cyc(1);
    check("cd3_q_at4", 32'(q), 32'd2);
    wait_cyc(4);
    check("cd3_q_at8", 32'(q), 32'd1);
    wait_cyc(4);
    check("cd3_q_at12", 32'(q), 32'd0);
    check("cd3_done_at12", 32'(done), 32'd1);
    check("cd3_expired_at12", 32'(expired), 32'd1);
    check("cd3_running_at12", 32'(running), 32'd0);
    wait_cyc(1);
    check("cd3_done_after", 32'(done), 32'd0);
    check("cd3_expired_after", 32'(expired), 32'd1);

    // Start in EXPIRED is ignored; load leaves it.
    pulse_start();
    wait_cyc(2);
    check("exp_start_ignored", 32'(expired), 32'd1);
    check("exp_q", 32'(q), 32'd0);
    pulse_load(16'd2);
    check("exp_load_q", 32'(q), 32'd2);
    check("exp_load_expired", 32'(expired), 32'd0);

    // Pause mid-period keeps the partial tick; resume finishes it.
    pulse_load(16'd5);
    pulse_start();
    wait_cyc(5);
    pulse_pause();
    check("pause_q", 32'(q), 32'd4);
    wait_cyc(10);
    check("paused_q_held", 32'(q), 32'd4);
    check("paused_running", 32'(running), 32'd0);
    pulse_start();
    wait_cyc(1);
    check("resume_q_1", 32'(q), 32'd4);
    wait_cyc(1);
    check("resume_q_2", 32'(q), 32'd3);
    wait_cyc(12);
    check("resume_q_zero", 32'(q), 32'd0);
    check("resume_done", 32'(done), 32'd1);

    // Start with q==0 is ignored; load beats start in the same cycle.
    pulse_load(16'd0);
    pulse_start();
    wait_cyc(5);
    check("zero_start_running", 32'(running), 32'd0);
    load_value = 16'd7; load = 1'b1; start = 1'b1;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    check("load_start_q", 32'(q), 32'd7);
    check("load_start_running", 32'(running), 32'd0);
    wait_cyc(6);
    check("load_start_q_held", 32'(q), 32'd7);

    // Pause on a tick cycle: decrement lands, then paused.
    pulse_load(16'd3);
    pulse_start();
    wait_cyc(3);
    pulse_pause();
    check("pause_tick_q", 32'(q), 32'd2);
    check("pause_tick_running", 32'(running), 32'd0);
    // Load on a tick cycle: load wins, no decrement.
    pulse_start();
    wait_cyc(3);
    pulse_load(16'd9);
    check("load_tick_q", 32'(q), 32'd9);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Auto reload: 2,1,2,1,2 with done every 8 cycles, never expired.
    pulse_load(16'd2);
    pulse_start();
    wait_cyc(4);
    check("ar_q_at4", 32'(q), 32'd1);
    wait_cyc(4);
    check("ar_q_at8", 32'(q), 32'd2);
    check("ar_done_at8", 32'(done), 32'd1);
    check("ar_running_at8", 32'(running), 32'd1);
    wait_cyc(8);
    check("ar_q_at16", 32'(q), 32'd2);
    check("ar_done_at16", 32'(done), 32'd1);
    check("ar_expired", 32'(expired), 32'd0);
`endif

    // Reset mid-count returns to IDLE with q=0.
    pulse_load(16'd5);
    pulse_start();
    wait_cyc(6);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    check("rst_mid_q", 32'(q), 32'd0);
    check("rst_mid_running", 32'(running), 32'd0);
    wait_cyc(5);
    check("rst_mid_q_held", 32'(q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
